memory_move_gen: RTL and testbench
==================================

Name: memory_move_gen

Overview:
- Move-event generator: the producer side of the 2-bit move code `x` consumed by the memory game turn/end FSM.
- Holds the card board, accepts player card picks, compares pairs, keeps per-player scores and a turn timer.
- Emits single-cycle codes:
  - 01 = turn passes
  - 10 = current player wins
  - 11 = tie
- Reads the FSM's `player` and `endState` back so scoring follows the turn the FSM holds.

Parameters:
- N_CARDS, 16, board size; must be even and ≥4. PAIRS = N_CARDS/2; WIN = PAIRS/2+1.
- VAL_W, 3, card face-value width.
- REVEAL_CYCLES, 50000000, cycles both picked cards stay shown before the result is emitted; must be ≥1.
- TURN_CYCLES, 500000000, cycles allowed per pick before timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: clear scores and matched mask, begin play
- load_en  in  1  board write strobe
- load_addr  in  clog2(N_CARDS)  board write index
- load_val  in  VAL_W  board write value
- pick_valid  in  1  pick strobe
- pick_idx  in  clog2(N_CARDS)  picked card index
- player  in  1  current turn from game FSM (0/1)
- endState  in  1  game FSM in an end state
- x  out  2  move code to game FSM; 00 = no event
- score0, score1  out  clog2(PAIRS+1)  pairs won per player
- matched  out  N_CARDS  bit i set when card i is matched
- first_idx, second_idx  out  clog2(N_CARDS)  current picks
- reveal  out  1  first_idx/second_idx faces are to be displayed
- pick_err  out  1  one-cycle pulse on a rejected pick
- busy  out  1  high in COMPARE/REVEAL/EMIT

Behaviour:
- Reset (rst high at an edge):
  - state IDLE.
  - x=00; scores=0; matched=0; first_idx=0; second_idx=0; reveal=0; pick_err=0; busy=0; timer=0.
  - Board contents are not reset.
- Board writes:
  - Accepted only in IDLE or DONE; ignored elsewhere.
  - Written on the edge where load_en is high.
- States: IDLE, WAIT_FIRST, WAIT_SECOND, COMPARE, REVEAL, EMIT, DONE.
- IDLE/DONE --start--> WAIT_FIRST
  - Clears scores and matched; loads timer = TURN_CYCLES.
  - start has priority over load_en and pick_valid in the same cycle.
- WAIT_FIRST:
  - Valid pick (index not matched) latches first_idx, sets reveal, reloads timer, goes to WAIT_SECOND.
  - A pick on a matched index pulses pick_err and does not change state.
- WAIT_SECOND:
  - Valid pick (not matched and ≠ first_idx) latches second_idx and goes to COMPARE.
  - Invalid pick pulses pick_err and does not change state.
- Timer in WAIT_FIRST/WAIT_SECOND:
  - Decrements each cycle.
  - When it reaches 0 with no valid pick in that cycle: set x=01 for one cycle, clear reveal, go to WAIT_FIRST, reload timer.
  - A valid pick in the expiry cycle wins over the timeout.
- COMPARE (1 cycle):
  - Compares board[first_idx] with board[second_idx].
  - On equal: sets both matched bits and increments the score of the `player` input.
- REVEAL: holds reveal=1 for REVEAL_CYCLES cycles, then goes to EMIT.
- EMIT (1 cycle), in priority order:
  - Current player's score == WIN → x=10, go to DONE.
  - Else all matched bits set → x=11, go to DONE.
  - Else mismatch → x=01, go to WAIT_FIRST.
  - Else (match) → x=00, go to WAIT_FIRST; the same player keeps the turn.
  - All cases clear reveal and reload the timer.
- Latency:
  - EMIT is the cycle REVEAL_CYCLES+2 cycles after the edge that accepts the second pick.
  - Each non-zero x is exactly one cycle wide and never in two consecutive cycles.
- Gating:
  - pick_valid is ignored with no pick_err in IDLE, COMPARE, REVEAL, EMIT and DONE.
  - pick_valid is also ignored whenever endState=1.
  - With endState=1 outside DONE, the block goes to DONE on the next edge and drives x=00.
- Widths: scores saturate at PAIRS; they never wrap.
- rst during any state returns to the reset values on that edge. Any pending event is discarded and not emitted.

Test Plan (all scenarios: N_CARDS=8, REVEAL_CYCLES=2, TURN_CYCLES=10, board = 0,1,2,3,0,1,2,3, player tied to the game FSM):
- Mismatch: start; pick 0 then 1.
  - Required: x=01 for exactly one cycle, 4 cycles after the second pick's accepting edge.
  - Required: matched=0; score0=0; player toggles to 1.
- Match: pick 0 then 4.
  - Required: matched=00010001; score0=1; x stays 00; player stays 0; reveal high for cycles 2..3 after the accepting edge.
- Win: player 0 matches pairs (0,4), (1,5), (2,6).
  - Required: x=10 after the third match; state DONE; score0=3; endState=1.
  - Required: further picks ignored; pick_err stays 0.
- Tie: alternate so each player matches 2 pairs, with mismatches between.
  - Required: final match gives x=11; score0=score1=2; matched=11111111.
- Errors and timeout:
  - Re-pick an index equal to first_idx → pick_err pulse, state unchanged.
  - Pick a matched card → pick_err pulse.
  - No pick for 10 cycles → x=01 once, turn passes.
  - Pick in the expiry cycle → pick accepted, no x.
- Reset mid-REVEAL: assert rst during REVEAL.
  - Required: next edge gives all outputs at reset values; no x event ever emitted.
  - Required: start afterwards resumes with scores 0.

Source files
------------

// File: rtl/memory_move_gen.sv
`default_nettype none
// ============================================================================
// Module   : memory_move_gen
// Brief    : Memory-game move-event generator: board, picks, pair compare,
//            scores and turn timer feeding the turn/end FSM via code x.
// Revision : 1.0 - initial release
// ============================================================================
module memory_move_gen #(
   parameter int N_CARDS       = 16,
   parameter int VAL_W         = 3,
   parameter int REVEAL_CYCLES = 50000000,
   parameter int TURN_CYCLES   = 500000000
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              load_en,
   input  logic [$clog2(N_CARDS)-1:0]        load_addr,
   input  logic [VAL_W-1:0]                  load_val,
   input  logic                              pick_valid,
   input  logic [$clog2(N_CARDS)-1:0]        pick_idx,
   input  logic                              player,
   input  logic                              endState,
   output logic [1:0]                        x,
   output logic [$clog2(N_CARDS/2+1)-1:0]    score0,
   output logic [$clog2(N_CARDS/2+1)-1:0]    score1,
   output logic [N_CARDS-1:0]                matched,
   output logic [$clog2(N_CARDS)-1:0]        first_idx,
   output logic [$clog2(N_CARDS)-1:0]        second_idx,
   output logic                              reveal,
   output logic                              pick_err,
   output logic                              busy
);

   localparam int c_IW    = $clog2(N_CARDS);
   localparam int c_PAIRS = N_CARDS / 2;
   localparam int c_WIN   = c_PAIRS / 2 + 1;
   localparam int c_SW    = $clog2(c_PAIRS + 1);
   localparam int c_TMAX  = (TURN_CYCLES > REVEAL_CYCLES) ? TURN_CYCLES : REVEAL_CYCLES;
   localparam int c_TW    = $clog2(c_TMAX + 1);

   localparam logic [c_TW-1:0] c_TURN      = c_TW'(TURN_CYCLES);
   localparam logic [c_TW-1:0] c_REVEAL    = c_TW'(REVEAL_CYCLES);
   localparam logic [c_TW-1:0] c_ONE       = c_TW'(1);
   localparam logic [c_SW-1:0] c_SCORE_MAX = c_SW'(c_PAIRS);
   localparam logic [c_SW-1:0] c_SCORE_WIN = c_SW'(c_WIN);
   localparam logic [c_SW-1:0] c_SCORE_INC = c_SW'(1);
   localparam logic [c_IW:0]   c_NCARDS    = (c_IW+1)'(N_CARDS);

   localparam logic [1:0] c_X_NONE = 2'b00;
   localparam logic [1:0] c_X_PASS = 2'b01;
   localparam logic [1:0] c_X_WIN  = 2'b10;
   localparam logic [1:0] c_X_TIE  = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_WAIT_FIRST  = 3'd1,
      ST_WAIT_SECOND = 3'd2,
      ST_COMPARE     = 3'd3,
      ST_REVEAL      = 3'd4,
      ST_EMIT        = 3'd5,
      ST_DONE        = 3'd6
   } state_t;

   state_t             r_state, w_state;
   logic [c_TW-1:0]    r_timer, w_timer;
   logic [1:0]         r_x, w_x;
   logic [c_SW-1:0]    r_score0, w_score0;
   logic [c_SW-1:0]    r_score1, w_score1;
   logic [N_CARDS-1:0] r_matched, w_matched;
   logic [c_IW-1:0]    r_first, w_first;
   logic [c_IW-1:0]    r_second, w_second;
   logic               r_reveal, w_reveal;
   logic               r_pick_err, w_pick_err;

   logic [VAL_W-1:0]   r_board [N_CARDS];

   logic               w_setup;
   logic               w_pick_ok_first;
   logic               w_pick_ok_second;
   logic               w_load_ok;
   logic [c_SW-1:0]    w_cur_score;

   assign w_setup          = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_pick_ok_first  = pick_valid && ({1'b0, pick_idx} < c_NCARDS) && !r_matched[pick_idx];
   assign w_pick_ok_second = w_pick_ok_first && (pick_idx != r_first);
   assign w_load_ok        = load_en && !start && !rst && w_setup && ({1'b0, load_addr} < c_NCARDS);
   assign w_cur_score      = player ? r_score1 : r_score0;

   // Board contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_load_ok) begin
         r_board[load_addr] <= load_val;
      end
   end

   always_comb begin
      w_state    = r_state;
      w_timer    = r_timer;
      w_x        = c_X_NONE;
      w_score0   = r_score0;
      w_score1   = r_score1;
      w_matched  = r_matched;
      w_first    = r_first;
      w_second   = r_second;
      w_reveal   = r_reveal;
      w_pick_err = 1'b0;

      if (w_setup && start) begin
         w_state   = ST_WAIT_FIRST;
         w_score0  = '0;
         w_score1  = '0;
         w_matched = '0;
         w_reveal  = 1'b0;
         w_timer   = c_TURN;
      end else if (endState && (r_state != ST_DONE)) begin
         // The game FSM has already ended the game: drop any pending event.
         w_state  = ST_DONE;
         w_reveal = 1'b0;
      end else begin
         case (r_state)
            ST_WAIT_FIRST, ST_WAIT_SECOND: begin
               if ((r_state == ST_WAIT_FIRST) && w_pick_ok_first) begin
                  w_first  = pick_idx;
                  w_reveal = 1'b1;
                  w_timer  = c_TURN;
                  w_state  = ST_WAIT_SECOND;
               end else if ((r_state == ST_WAIT_SECOND) && w_pick_ok_second) begin
                  w_second = pick_idx;
                  w_state  = ST_COMPARE;
               end else begin
                  w_pick_err = pick_valid;
                  if (r_timer <= c_ONE) begin
                     w_x      = c_X_PASS;
                     w_reveal = 1'b0;
                     w_timer  = c_TURN;
                     w_state  = ST_WAIT_FIRST;
                  end else begin
                     w_timer = r_timer - c_ONE;
                  end
               end
            end
            ST_COMPARE: begin
               if (r_board[r_first] == r_board[r_second]) begin
                  w_matched[r_first]  = 1'b1;
                  w_matched[r_second] = 1'b1;
                  if (!player && (r_score0 != c_SCORE_MAX)) w_score0 = r_score0 + c_SCORE_INC;
                  if (player && (r_score1 != c_SCORE_MAX))  w_score1 = r_score1 + c_SCORE_INC;
               end
               w_timer = c_REVEAL;
               w_state = ST_REVEAL;
            end
            ST_REVEAL: begin
               if (r_timer <= c_ONE) begin
                  w_state = ST_EMIT;
               end else begin
                  w_timer = r_timer - c_ONE;
               end
            end
            ST_EMIT: begin
               w_reveal = 1'b0;
               w_timer  = c_TURN;
               if (w_cur_score == c_SCORE_WIN) begin
                  w_x     = c_X_WIN;
                  w_state = ST_DONE;
               end else if (&r_matched) begin
                  w_x     = c_X_TIE;
                  w_state = ST_DONE;
               end else if (!r_matched[r_first]) begin
                  // first card still unmatched means the pair differed
                  w_x     = c_X_PASS;
                  w_state = ST_WAIT_FIRST;
               end else begin
                  w_state = ST_WAIT_FIRST;
               end
            end
            ST_IDLE, ST_DONE: begin
               w_state = r_state;
            end
            default: begin
               w_state = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_timer    <= '0;
         r_x        <= c_X_NONE;
         r_score0   <= '0;
         r_score1   <= '0;
         r_matched  <= '0;
         r_first    <= '0;
         r_second   <= '0;
         r_reveal   <= 1'b0;
         r_pick_err <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_timer    <= w_timer;
         r_x        <= w_x;
         r_score0   <= w_score0;
         r_score1   <= w_score1;
         r_matched  <= w_matched;
         r_first    <= w_first;
         r_second   <= w_second;
         r_reveal   <= w_reveal;
         r_pick_err <= w_pick_err;
      end
   end

   assign x          = r_x;
   assign score0     = r_score0;
   assign score1     = r_score1;
   assign matched    = r_matched;
   assign first_idx  = r_first;
   assign second_idx = r_second;
   assign reveal     = r_reveal;
   assign pick_err   = r_pick_err;
   assign busy       = (r_state == ST_COMPARE) || (r_state == ST_REVEAL) || (r_state == ST_EMIT);

endmodule
`default_nettype wire

// File: tb/tb_memory_move_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_move_gen
// Brief    : Bench for memory_move_gen: fixed game tables, corner sequences,
//            and random games against a turn-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_move_gen;

   localparam int N   = 8;
   localparam int RV  = 2;
   localparam int TC  = 10;
   localparam int WIN = 3;

   logic       clk = 1'b0;
   logic       rst, start, load_en, pick_valid;
   logic       player = 1'b0;
   logic       endst  = 1'b0;
   logic [2:0] load_addr, load_val, pick_idx;
   logic [1:0] x;
   logic [2:0] score0, score1, first_idx, second_idx;
   logic [7:0] matched;
   logic       reveal, pick_err, busy;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int st;
      int a;
      int b;
      int ex;
      int s0;
      int s1;
      int m;
   } vec_t;

   always #5 clk = ~clk;

   memory_move_gen #(
      .N_CARDS(N), .VAL_W(3), .REVEAL_CYCLES(RV), .TURN_CYCLES(TC)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .load_en(load_en), .load_addr(load_addr), .load_val(load_val),
      .pick_valid(pick_valid), .pick_idx(pick_idx),
      .player(player), .endState(endst),
      .x(x), .score0(score0), .score1(score1), .matched(matched),
      .first_idx(first_idx), .second_idx(second_idx),
      .reveal(reveal), .pick_err(pick_err), .busy(busy)
   );

   // Minimal game FSM: turn passes on 01, game ends on 10/11.
   always @(posedge clk) begin
      if (rst || start) begin
         player <= 1'b0;
         endst  <= 1'b0;
      end else if (x == 2'b01) begin
         player <= ~player;
      end else if (x[1]) begin
         endst <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic load(input int addr, input int val);
      load_en   = 1'b1;
      load_addr = 3'(addr);
      load_val  = 3'(val);
      tick();
      load_en   = 1'b0;
   endtask

   task automatic start_game();
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_score0", score0, 0);
      chk("start_score1", score1, 0);
      chk("start_matched", matched, 0);
      chk("start_busy", busy, 0);
   endtask

   task automatic do_pick(input int idx);
      pick_valid = 1'b1;
      pick_idx   = 3'(idx);
      tick();
      pick_valid = 1'b0;
   endtask

   // Two picks, then x must appear exactly RV+2 edges after the second pick.
   task automatic play_turn(input int a, input int b, input int ex,
                            input int s0, input int s1, input int m);
      do_pick(a);
      chk("first_idx", first_idx, a);
      chk("first_pick_err", pick_err, 0);
      do_pick(b);
      chk("second_idx", second_idx, b);
      for (int k = 1; k <= RV + 2; k++) begin
         tick();
         chk("x_timing", x, (k == RV + 2) ? ex : 0);
         chk("reveal_window", reveal, (k < RV + 2) ? 1 : 0);
         chk("busy_window", busy, (k < RV + 2) ? 1 : 0);
      end
      chk("score0", score0, s0);
      chk("score1", score1, s1);
      chk("matched", matched, m);
      tick();
      chk("x_one_cycle", x, 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vec_t tbl[10];
      int   bd[8], pos[8], u[8], c[8];
      int   a, b, code, nu, nb, sc0, sc1, mp, v, j, tmp, cur;
      logic [7:0] mm;
      bit   fin;

      // game A: two mismatches, then player 0 wins; game B: 2-2 tie
      tbl[0] = '{1, 0, 1, 1, 0, 0, 'h00};
      tbl[1] = '{0, 1, 2, 1, 0, 0, 'h00};
      tbl[2] = '{0, 0, 4, 0, 1, 0, 'h11};
      tbl[3] = '{0, 1, 5, 0, 2, 0, 'h33};
      tbl[4] = '{0, 2, 6, 2, 3, 0, 'h77};
      tbl[5] = '{1, 0, 4, 0, 1, 0, 'h11};
      tbl[6] = '{0, 1, 5, 0, 2, 0, 'h33};
      tbl[7] = '{0, 2, 3, 1, 2, 0, 'h33};
      tbl[8] = '{0, 2, 6, 0, 2, 1, 'h77};
      tbl[9] = '{0, 3, 7, 3, 2, 2, 'hFF};

      rst = 1'b1; start = 1'b0; load_en = 1'b0; load_addr = '0; load_val = '0;
      pick_valid = 1'b0; pick_idx = '0;
      tick();
      tick();
      chk("rst_x", x, 0);
      chk("rst_score0", score0, 0);
      chk("rst_score1", score1, 0);
      chk("rst_matched", matched, 0);
      chk("rst_first", first_idx, 0);
      chk("rst_second", second_idx, 0);
      chk("rst_reveal", reveal, 0);
      chk("rst_pick_err", pick_err, 0);
      chk("rst_busy", busy, 0);
      rst = 1'b0;

      for (int i = 0; i < N; i++) load(i, i % 4);

      for (int i = 0; i < 10; i++) begin
         if (tbl[i].st != 0) start_game();
         play_turn(tbl[i].a, tbl[i].b, tbl[i].ex, tbl[i].s0, tbl[i].s1, tbl[i].m);
         if (i == 4) begin
            chk("win_endState", endst, 1);
            chk("win_busy", busy, 0);
            pick_valid = 1'b1;
            pick_idx   = 3'd3;
            tick();
            pick_valid = 1'b0;
            chk("done_pick_err", pick_err, 0);
            chk("done_x", x, 0);
            chk("done_first", first_idx, 2);
            chk("done_matched", matched, 'h77);
         end
      end

      // Errors, timeout, expiry-cycle pick, reset during REVEAL
      start_game();
      load(4, 7);
      play_turn(0, 4, 0, 1, 0, 'h11);
      do_pick(4);
      chk("err_matched_first", pick_err, 1);
      chk("err_matched_first_reveal", reveal, 0);
      tick();
      chk("err_pulse_width", pick_err, 0);
      do_pick(1);
      pick_valid = 1'b1;
      pick_idx   = 3'd1;
      tick();
      chk("err_same_idx", pick_err, 1);
      chk("err_same_first", first_idx, 1);
      chk("err_same_reveal", reveal, 1);
      chk("err_same_busy", busy, 0);
      pick_idx = 3'd0;
      tick();
      chk("err_matched_second", pick_err, 1);
      pick_valid = 1'b0;
      for (int k = 3; k <= TC; k++) begin
         tick();
         chk("timeout_x", x, (k == TC) ? 1 : 0);
      end
      chk("timeout_reveal", reveal, 0);
      chk("timeout_busy", busy, 0);
      for (int k = 1; k < TC; k++) begin
         tick();
         chk("pre_expiry_x", x, 0);
      end
      do_pick(2);
      chk("expiry_x", x, 0);
      chk("expiry_first", first_idx, 2);
      chk("expiry_reveal", reveal, 1);
      do_pick(6);
      tick();
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_score1", score1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_x", x, 0);
      chk("midrst_score0", score0, 0);
      chk("midrst_score1", score1, 0);
      chk("midrst_matched", matched, 0);
      chk("midrst_first", first_idx, 0);
      chk("midrst_second", second_idx, 0);
      chk("midrst_reveal", reveal, 0);
      chk("midrst_pick_err", pick_err, 0);
      chk("midrst_busy", busy, 0);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("midrst_no_event", x, 0);
      end
      start_game();
      play_turn(0, 4, 0, 1, 0, 'h11);

      // Random games on shuffled pair boards, predicted turn by turn
      for (int g = 0; g < 12; g++) begin
         rst = 1'b1;
         tick();
         rst = 1'b0;
         for (int i = 0; i < N; i++) pos[i] = i;
         for (int i = N - 1; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = pos[i]; pos[i] = pos[j]; pos[j] = tmp;
         end
         for (int p = 0; p < N / 2; p++) begin
            v = int'($urandom_range(0, 7));
            bd[pos[2*p]]   = v;
            bd[pos[2*p+1]] = v;
         end
         for (int i = 0; i < N; i++) load(i, bd[i]);
         start_game();
         mm = '0; sc0 = 0; sc1 = 0; mp = 0; fin = 1'b0;
         for (int t = 0; t < 40 && !fin; t++) begin
            nu = 0;
            for (int i = 0; i < N; i++) if (!mm[i]) begin u[nu] = i; nu++; end
            a  = u[$urandom_range(0, nu - 1)];
            nb = 0;
            if ($urandom_range(0, 1) == 1)
               for (int i = 0; i < N; i++)
                  if (!mm[i] && i != a && bd[i] == bd[a]) begin c[nb] = i; nb++; end
            if (nb == 0)
               for (int i = 0; i < N; i++)
                  if (!mm[i] && i != a) begin c[nb] = i; nb++; end
            b = c[$urandom_range(0, nb - 1)];
            if (bd[a] == bd[b]) begin
               mm[a] = 1'b1;
               mm[b] = 1'b1;
               if (mp == 0) begin if (sc0 < N / 2) sc0++; cur = sc0; end
               else         begin if (sc1 < N / 2) sc1++; cur = sc1; end
               code = (cur == WIN) ? 2 : ((&mm) ? 3 : 0);
            end else begin
               code = 1;
            end
            play_turn(a, b, code, sc0, sc1, int'(mm));
            if (code == 1) mp = 1 - mp;
            if (code >= 2) fin = 1'b1;
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
